output_buffer_reader: RTL
=========================

Name: output_buffer_reader

Overview:
- Receiving end of the accumulator's output-buffer write interface (data, address, enable).
- Stores finished 32-bit results in a DEPTH-entry register file with per-entry valid bits.
- Streams a requested address window to the host over a valid/ready interface. Each entry is cleared as it is consumed.
- Sits between the systolic array accumulators and the host/DMA readout path.

Parameters:
- DEPTH, 16, number of buffer entries (power of two).
- ADDR_W, 4, address width, log2(DEPTH).
- DATA_W, 32, result word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- output_buffer_enable  input  1  write strobe from accumulator.
- output_buffer_addr  input  ADDR_W  write address.
- output_data  input  DATA_W  write data.
- rd_start  input  1  one-cycle pulse that starts a readout burst.
- rd_base  input  ADDR_W  first address of the burst.
- rd_count  input  ADDR_W+1  number of words in the burst.
- out_valid  output  1  stream word valid.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  stream word.
- out_addr  output  ADDR_W  buffer address of the current word.
- out_last  output  1  current word is the final word of the burst.
- busy  output  1  burst in progress.
- occupancy  output  ADDR_W+1  number of valid entries.
- overwrite_err  output  1  sticky: a write hit an entry not yet read.
- err_clr  input  1  clears overwrite_err.

Behaviour:
- Reset (async, active-high): all valid bits=0, state=IDLE, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, occupancy=0, overwrite_err=0. Storage contents are don't-care.
- Reset asserted mid-burst aborts the burst immediately; the word in flight is lost.
- Write path, every cycle, any state:
  - If output_buffer_enable is high: mem[addr]<=data and valid[addr]<=1.
  - If valid[addr] was already 1 and that entry is not being consumed this cycle, set overwrite_err.
- Error flag: err_clr clears overwrite_err. When a set and a clear occur in the same cycle, set wins.
- FSM states: IDLE, FETCH, SEND.
- IDLE:
  - busy=0.
  - rd_start with rd_count!=0: latch ptr=rd_base and remaining=min(rd_count,DEPTH); go to FETCH. busy rises the next cycle.
  - rd_count==0: the request is ignored.
- FETCH (busy=1):
  - If valid[ptr]=1, or a write to ptr occurs this cycle: load out_data, set out_addr=ptr, clear valid[ptr], set out_valid=1, go to SEND.
  - On a same-cycle write to ptr, the incoming write data is forwarded and takes priority. The entry ends invalid, and no overwrite_err is raised.
  - Otherwise stay in FETCH: the reader stalls until the accumulator writes that entry. There is no timeout.
- SEND:
  - out_data, out_addr and out_last stay stable while out_valid=1 and out_ready=0.
  - On out_valid and out_ready: decrement remaining and set ptr=(ptr+1) mod DEPTH, wrapping 15->0.
  - If remaining was 1: out_valid=0 and go to IDLE. Otherwise go to FETCH.
- Latency and throughput:
  - The first word is valid 2 cycles after rd_start when the entry is already valid.
  - Maximum throughput is one word per 2 cycles.
- out_last = out_valid and (remaining==1).
- rd_start while busy is ignored. There is no queueing.
- occupancy equals the population count of the valid bits, maintained incrementally:
  - +1 for a write to an invalid entry.
  - -1 for a consume of a valid entry.
  - Unchanged for a forwarded write+consume or an overwrite.
  - It never exceeds DEPTH and never underflows.
- out_data is registered. There is no combinational path from out_ready to out_valid.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, FETCH=2'd1, SEND=2'd2);
  - DEPTH, ADDR_W and DATA_W defaults shared with the accumulator;
  - the count width constant ADDR_W+1.
- One sub-module is natural: obuf_regfile. It holds the DEPTH x DATA_W storage plus valid bits, with one write port, one read port, and a clear-on-read strobe.
- The top level holds the FSM, pointers, occupancy and the error flag.

Test Plan:
- Write 0xA0..0xA3 to addresses 0..3, then rd_start base=0 count=4 with out_ready=1 -> out_data A0,A1,A2,A3 at addresses 0..3, out_last only on A3, occupancy goes 4->0, busy falls after the last word.
- Write addresses 14, 15, 0, 1, then burst base=14 count=4 -> addresses 14, 15, 0, 1 in order (wraparound), no error.
- Burst base=5 count=1 while entry 5 is empty; write 0x55 to address 5 three cycles later -> out_data=0x55 via forwarding in the write cycle, valid[5]=0 afterwards, occupancy stays 0.
- Word pending with out_ready=0 for 5 cycles -> out_valid held high and out_data/out_addr stable; a rd_start during the burst is ignored.
- Write address 3 twice without a read -> overwrite_err=1 and occupancy=1; assert err_clr -> overwrite_err=0; rd_count=0 and rd_count=20 -> no burst, and a clamped 16-word burst, respectively.
- Assert rst asynchronously mid-SEND -> all outputs return to reset values without waiting for a clock edge, and occupancy=0.

Source files
------------

// File: rtl/output_buffer_reader_pkg.sv
// Shared constants and FSM encoding for the output-buffer readout path.
package output_buffer_reader_pkg;

  localparam int unsigned OB_DEPTH  = 16;
  localparam int unsigned OB_ADDR_W = 4;
  localparam int unsigned OB_DATA_W = 32;
  localparam int unsigned OB_CNT_W  = OB_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } obr_state_t;

endpackage

// File: rtl/output_buffer_reader_regfile.sv
// DEPTH x DATA_W result storage with per-entry valid bits and clear-on-read.
module obuf_regfile
  import output_buffer_reader_pkg::*;
#(
  parameter int unsigned DEPTH  = OB_DEPTH,
  parameter int unsigned ADDR_W = OB_ADDR_W,
  parameter int unsigned DATA_W = OB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Clear is applied after set so a same-cycle write to the consumed entry leaves it invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (wr_en) valid[wr_addr] <= 1'b1;
      if (clr)   valid[rd_addr] <= 1'b0;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign rd_valid = valid[rd_addr];
  assign wr_valid = valid[wr_addr];

endmodule

// File: rtl/output_buffer_reader.sv
// Output-buffer receiver: stores accumulator results and streams address windows to the host.
module output_buffer_reader
  import output_buffer_reader_pkg::*;
#(
  parameter int unsigned DEPTH  = OB_DEPTH,
  parameter int unsigned ADDR_W = OB_ADDR_W,
  parameter int unsigned DATA_W = OB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              output_buffer_enable,
  input  logic [ADDR_W-1:0] output_buffer_addr,
  input  logic [DATA_W-1:0] output_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic [ADDR_W:0]   occupancy,
  output logic              overwrite_err,
  input  logic              err_clr
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  obr_state_t        state;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  remaining;

  logic              wr_valid;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_hits_ptr;
  logic              fwd;
  logic              consume;
  logic [DATA_W-1:0] fetch_data;
  logic              occ_inc;
  logic              occ_dec;
  logic              ow_set;

  obuf_regfile #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (output_buffer_enable),
    .wr_addr  (output_buffer_addr),
    .wr_data  (output_data),
    .wr_valid (wr_valid),
    .rd_addr  (ptr),
    .clr      (consume),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always_comb begin
    wr_hits_ptr = output_buffer_enable && (output_buffer_addr == ptr);
    fwd         = (state == FETCH) && wr_hits_ptr;
    consume     = (state == FETCH) && (rd_valid || fwd);
    fetch_data  = fwd ? output_data : rd_data;
    // A write into the entry being consumed is absorbed by the read, not counted or flagged.
    ow_set      = output_buffer_enable && wr_valid && !(consume && wr_hits_ptr);
    occ_inc     = output_buffer_enable && !wr_valid && !(consume && wr_hits_ptr);
    occ_dec     = consume && rd_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_start && (rd_count != '0)) begin
            ptr       <= rd_base;
            remaining <= (rd_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : rd_count;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (consume) begin
            out_data  <= fetch_data;
            out_addr  <= ptr;
            out_valid <= 1'b1;
            out_last  <= (remaining == CNT_W'(1));
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (occ_inc && !occ_dec) begin
      occupancy <= occupancy + 1'b1;
    end else if (occ_dec && !occ_inc) begin
      occupancy <= occupancy - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overwrite_err <= 1'b0;
    end else if (ow_set) begin
      overwrite_err <= 1'b1;
    end else if (err_clr) begin
      overwrite_err <= 1'b0;
    end
  end

endmodule
